// File: rtl/sensor_scan_if.sv
// Sensor-side bundle for the scan scheduler: control inputs, per-channel
// trigger/echo pins and the measurement result.
interface sensor_scan_if #(
  parameter int NUM_SENSORS = 4
) ();
  localparam int CH_W = $clog2(NUM_SENSORS);

  logic                   enable;
  logic [NUM_SENSORS-1:0] chan_mask;
  logic [NUM_SENSORS-1:0] TRIGGER;
  logic [NUM_SENSORS-1:0] ECHO;
  logic [15:0]            DISTANCE;
  logic [CH_W-1:0]        DISTANCE_CH;
  logic                   DISTANCE_VALID;
  logic                   TIMEOUT;
  logic                   busy;

  modport master (
    output enable, chan_mask, ECHO,
    input  TRIGGER, DISTANCE, DISTANCE_CH, DISTANCE_VALID, TIMEOUT, busy
  );

  modport slave (
    input  enable, chan_mask, ECHO,
    output TRIGGER, DISTANCE, DISTANCE_CH, DISTANCE_VALID, TIMEOUT, busy
  );
endinterface

// File: rtl/sensor_scan_scheduler.sv
// Round-robin ultrasonic ranger scheduler: one trigger/echo timing engine
// shared across channels, echo width converted to cm by a running sub-counter.
module sensor_scan_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int TRIG_CYCLES    = 1000,
  parameter int CYC_PER_CM     = 5800,
  parameter int TIMEOUT_CYCLES = 3800000,
  parameter int GUARD_CYCLES   = 6000000
) (
  input  logic         clk,
  input  logic         rst,
  sensor_scan_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_SENSORS);
  localparam int MAX_A = (TRIG_CYCLES > GUARD_CYCLES) ? TRIG_CYCLES : GUARD_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int SUB_W = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GUARD} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, nxt_ch;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUB_W-1:0]  sub_q, sub_d, step_sub, sub_base;
  logic [15:0]       cm_q, cm_d, step_cm, cm_base;
  logic              echo_q, echo_d, echo_cur, any_ch, tmo_hit;
  logic [15:0]       dist_q, dist_d;
  logic [CH_W-1:0]   dch_q, dch_d;
  logic              to_q, to_d, vld_q, vld_d;

  // Next enabled channel strictly after the pointer; the smallest offset wins.
  always_comb begin
    nxt_ch = ch_q;
    any_ch = |bus.chan_mask;
    for (int i = NUM_SENSORS; i >= 1; i--) begin
      int j;
      j = int'(ch_q) + i;
      if (j >= NUM_SENSORS) j = j - NUM_SENSORS;
      if (bus.chan_mask[CH_W'(j)]) nxt_ch = CH_W'(j);
    end
  end

  assign echo_cur = bus.ECHO[ch_q];
  assign tmo_hit  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // One echo-high cycle of the cm converter; the rise cycle starts from zero.
  always_comb begin
    sub_base = (state_q == MEASURE) ? sub_q : '0;
    cm_base  = (state_q == MEASURE) ? cm_q  : '0;
    if (sub_base == SUB_W'(CYC_PER_CM - 1)) begin
      step_sub = '0;
      step_cm  = (cm_base == 16'hFFFE) ? cm_base : cm_base + 16'd1;
    end else begin
      step_sub = sub_base + SUB_W'(1);
      step_cm  = cm_base;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    echo_d  = echo_cur;
    dist_d  = dist_q;
    dch_d   = dch_q;
    to_d    = to_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable && any_ch) begin
          ch_d    = nxt_ch;
          cnt_d   = '0;
          state_d = TRIG;
        end
      end
      TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RISE, MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit) begin
          // Timeout takes priority over an echo edge in the same cycle.
          dist_d  = 16'hFFFF;
          to_d    = 1'b1;
          dch_d   = ch_q;
          vld_d   = 1'b1;
          state_d = REPORT;
        end else if (state_q == WAIT_RISE) begin
          if (echo_cur && !echo_q) begin
            sub_d   = step_sub;
            cm_d    = step_cm;
            state_d = MEASURE;
          end
        end else if (echo_cur) begin
          sub_d = step_sub;
          cm_d  = step_cm;
        end else begin
          dist_d  = cm_q;
          to_d    = 1'b0;
          dch_d   = ch_q;
          vld_d   = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        cnt_d   = '0;
        state_d = GUARD;
      end
      GUARD: begin
        if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
          cnt_d = '0;
          if (bus.enable && any_ch) begin
            ch_d    = nxt_ch;
            state_d = TRIG;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= CH_W'(NUM_SENSORS - 1);
      cnt_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      echo_q  <= 1'b0;
      dist_q  <= '0;
      dch_q   <= '0;
      to_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      echo_q  <= echo_d;
      dist_q  <= dist_d;
      dch_q   <= dch_d;
      to_q    <= to_d;
      vld_q   <= vld_d;
    end
  end

  // Trigger decodes straight from state so an async reset drops it at once.
  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_trig
    assign bus.TRIGGER[i] = (state_q == TRIG) && (ch_q == CH_W'(i));
  end

  assign bus.DISTANCE       = dist_q;
  assign bus.DISTANCE_CH    = dch_q;
  assign bus.DISTANCE_VALID = vld_q;
  assign bus.TIMEOUT        = to_q;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Bench for sensor_scan_scheduler: directed and randomized slots checked
// against a slot-level model of selection order, distance, timeout and timing.
module tb_sensor_scan_scheduler;
  localparam int N    = 4;
  localparam int TRIG = 10;
  localparam int CPC  = 4;
  localparam int TMO  = 200;
  localparam int GRD  = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sensor_scan_if #(.NUM_SENSORS(N)) ifc ();

  sensor_scan_scheduler #(
    .NUM_SENSORS(N), .TRIG_CYCLES(TRIG), .CYC_PER_CM(CPC),
    .TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GRD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           ptr;
  logic [N-1:0] mask_v;
  int           last_v;
  bit           has_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_ch(input int p, input logic [N-1:0] m);
    logic [N-1:0] s;
    for (int i = 1; i <= N; i++) begin
      s = m >> ((p + i) % N);
      if (s[0]) return (p + i) % N;
    end
    return 0;
  endfunction

  function automatic bit echo_at(input int j, input int p, input int d, input int w);
    if (j <= p) return 1'b1;
    if (j <= p + d) return 1'b0;
    if (j <= p + d + w) return 1'b1;
    return 1'b0;
  endfunction

  // Random noise on every other channel; the selected one gets b.
  task automatic drive(input int ch, input bit b);
    logic [N-1:0] r;
    r = N'($urandom);
    r = (r & ~(N'(1) << ch)) | (N'(b) << ch);
    ifc.ECHO = r;
  endtask

  // One slot: echo high for j<=p, low for d cycles, high w cycles, then low,
  // where j=1 is the first cycle after the trigger falls.
  task automatic run_slot(input int p, input int d, input int w, input int drop_j, input int new_mask);
    int ec, n, th, vj, endj, exp_vj;
    bit seen, to_exp;
    logic [N-1:0] exp_trig;
    logic [15:0] dsav;
    ec = next_ch(ptr, mask_v);
    exp_trig = N'(1) << ec;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      seen = (ifc.TRIGGER != '0);
      drive(ec, p > 0);
      n++;
    end
    chk("trig_seen", 32'(seen), 1);
    if (!seen) return;
    if (has_last) chk("guard_gap", cyc - last_v, GRD + 1);
    chk("trig_ch", 32'(ifc.TRIGGER), 32'(exp_trig));
    chk("busy_trig", 32'(ifc.busy), 1);
    th = 1;
    while (th < 100) begin
      @(negedge clk);
      if (ifc.TRIGGER !== exp_trig) break;
      drive(ec, p > 0);
      th++;
    end
    chk("trig_width", th, TRIG);
    chk("trig_low", 32'(ifc.TRIGGER), 0);
    vj = 0;
    for (int j = 1; j <= 300; j++) begin
      if (j > 1) @(negedge clk);
      if (ifc.DISTANCE_VALID === 1'b1) begin
        vj = j;
        break;
      end
      drive(ec, echo_at(j, p, d, w));
      if (j == drop_j) ifc.enable = 1'b0;
      if (j == 5 && new_mask >= 0) begin
        mask_v = N'(new_mask);
        ifc.chan_mask = mask_v;
      end
    end
    endj   = p + d + w + 1;
    to_exp = !(w > 0 && endj <= TMO - 1);
    exp_vj = to_exp ? TMO + 1 : endj + 1;
    chk("valid_lat", vj, exp_vj);
    chk("distance", 32'(ifc.DISTANCE), to_exp ? 32'hFFFF : w / CPC);
    chk("timeout", 32'(ifc.TIMEOUT), 32'(to_exp));
    chk("dist_ch", 32'(ifc.DISTANCE_CH), ec);
    chk("busy_rep", 32'(ifc.busy), 1);
    dsav     = ifc.DISTANCE;
    last_v   = cyc;
    has_last = 1'b1;
    ptr      = ec;
    @(negedge clk);
    drive(ec, 1'b0);
    chk("valid_pulse", 32'(ifc.DISTANCE_VALID), 0);
    chk("dist_hold", 32'(ifc.DISTANCE), 32'(dsav));
  endtask

  initial begin
    int n, bad, ec;
    rst = 1'b1;
    ifc.enable = 1'b0;
    ifc.chan_mask = '0;
    ifc.ECHO = '0;
    ptr = N - 1;
    has_last = 1'b0;
    mask_v = '0;
    repeat (2) @(negedge clk);
    chk("rst_trigger", 32'(ifc.TRIGGER), 0);
    chk("rst_distance", 32'(ifc.DISTANCE), 0);
    chk("rst_dist_ch", 32'(ifc.DISTANCE_CH), 0);
    chk("rst_valid", 32'(ifc.DISTANCE_VALID), 0);
    chk("rst_timeout", 32'(ifc.TIMEOUT), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    rst = 1'b0;

    // Single channel
    mask_v = 4'b0001; ifc.chan_mask = mask_v; ifc.enable = 1'b1;
    run_slot(0, 5, 22, -1, -1);

    // Round robin over 0,1,3
    mask_v = 4'b1011; ifc.chan_mask = mask_v;
    for (int k = 0; k < 4; k++) run_slot(0, $urandom_range(0, 20), 8, -1, -1);

    // Timeout, then a normal slot to confirm the guard gap
    mask_v = 4'b0100; ifc.chan_mask = mask_v;
    run_slot(0, 0, 0, -1, -1);
    run_slot(0, 3, 17, -1, -1);

    // Echo stuck high before the trigger
    mask_v = 4'b0001; ifc.chan_mask = mask_v;
    run_slot(30, 10, 12, -1, -1);

    // Timeout boundary: fall just before vs. on the timeout cycle
    run_slot(0, 5, 193, -1, -1);
    run_slot(0, 5, 194, -1, -1);

    // Random slots with mid-slot mask changes
    for (int k = 0; k < 8; k++) begin
      int p, d;
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      d = (p > 0) ? $urandom_range(1, 30) : $urandom_range(0, 30);
      run_slot(p, d, $urandom_range(0, 180), -1, $urandom_range(1, 15));
    end

    // Enable dropped during MEASURE
    mask_v = 4'b0011; ifc.chan_mask = mask_v;
    run_slot(0, 4, 30, 7, -1);
    n = 0;
    while (ifc.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("guard_then_idle", cyc - last_v, GRD + 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ifc.TRIGGER !== '0 || ifc.busy !== 1'b0) bad++;
    end
    chk("idle_after_drop", bad, 0);
    has_last = 1'b0;

    // Empty mask keeps the block idle
    mask_v = '0; ifc.chan_mask = mask_v; ifc.enable = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0 || ifc.TRIGGER !== '0) bad++;
    end
    chk("mask_zero_idle", bad, 0);

    // Async reset during TRIG
    mask_v = 4'b0111; ifc.chan_mask = mask_v;
    ec = next_ch(ptr, mask_v);
    n = 0;
    while (ifc.TRIGGER === '0 && n < 50) begin
      @(negedge clk);
      drive(ec, 1'b0);
      n++;
    end
    chk("pre_rst_trig", 32'(ifc.TRIGGER), 32'(N'(1) << ec));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_trig_drop", 32'(ifc.TRIGGER), 0);
    chk("rst_busy_drop", 32'(ifc.busy), 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ifc.DISTANCE_VALID !== 1'b0) bad++;
    end
    chk("rst_no_valid", bad, 0);
    rst = 1'b0;
    ptr = N - 1;
    run_slot(0, 2, 9, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
